scene_renderer: RTL

- Parametrised raster-scan pixel generator with built-in character physics.
- Sits between the game top level and `vga_adapter`.
- Each clock it emits one pixel (`x`, `y`, `colour`, `plot`) of a scene made of N programmable platforms, a grass strip and the player character.
- A tick divider drives a GROUND/RISE/FALL state machine with platform landing, edge fall-off and screen-edge clamping.

---
 rtl/scene_renderer.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/scene_renderer.sv
// -----------------------------------------------------------------------------
// scene_renderer
//
// Raster-scan pixel generator for the game scene, placed between the game top
// level and vga_adapter. Every clock it emits one registered pixel of a scene
// made of N_PLAT programmable platforms, a grass strip along the bottom edge
// and the player character. A tick divider paces a GROUND/RISE/FALL physics
// state machine that handles walking, jumping, platform landing, walking off
// platform edges and clamping at the screen edges.
//
// Build option:
//   SCENE_RENDERER_FRAME_LATCH_EN - when defined, the character is drawn from
//   a snapshot of its position taken at scan origin, so it moves only between
//   frames. When undefined, the live position is drawn and no snapshot
//   registers exist.
//
// Ports:
//   clock, resetn           system clock, asynchronous active-low reset
//   move_right, move_left   walk controls, active-high
//   jump_n                  jump request, active-low
//   plat_x0/plat_x1/plat_y  packed platform left x, right x (inclusive), row;
//                           platform i sits at bits [i*COORD_W +: COORD_W]
//   x, y, colour, plot      registered pixel stream (one clock latency)
//   frame_start             high while the output pixel is (0,0)
//   char_x, char_y          live character position
//   state                   physics state: GROUND=0, RISE=1, FALL=2
// -----------------------------------------------------------------------------
module scene_renderer #(
   parameter int          H_RES     = 320,
   parameter int          V_RES     = 240,
   parameter int          COORD_W   = 10,
   parameter int          N_PLAT    = 5,
   parameter int          TICK_DIV  = 833333,
   parameter int          JUMP_H    = 40,
   parameter int          GROUND_Y  = 205,
   parameter logic [2:0]  BG_COLOUR = 3'b001
) (
   input  logic                        clock,
   input  logic                        resetn,
   input  logic                        move_right,
   input  logic                        move_left,
   input  logic                        jump_n,
   input  logic [N_PLAT*COORD_W-1:0]   plat_x0,
   input  logic [N_PLAT*COORD_W-1:0]   plat_x1,
   input  logic [N_PLAT*COORD_W-1:0]   plat_y,
   output logic [COORD_W-1:0]          x,
   output logic [COORD_W-1:0]          y,
   output logic [2:0]                  colour,
   output logic                        plot,
   output logic                        frame_start,
   output logic [COORD_W-1:0]          char_x,
   output logic [COORD_W-1:0]          char_y,
   output logic [1:0]                  state
);

   // One extra bit so "a + k" never wraps before a comparison.
   localparam int EW = COORD_W + 1;
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [1:0] {
      ST_GROUND = 2'd0,
      ST_RISE   = 2'd1,
      ST_FALL   = 2'd2
   } phys_state_t;

   function automatic logic [EW-1:0] ext(input logic [COORD_W-1:0] v);
      return {1'b0, v};
   endfunction

   logic [COORD_W-1:0] sx, sy;
   logic [TW-1:0]      tick_cnt;
   logic               tick;
   logic               at_origin;
   phys_state_t        st;
   logic [COORD_W-1:0] apex;
   logic               supported;
   logic               on_plat;
   logic [COORD_W-1:0] cx, cy;
   logic [2:0]         pix;

   assign at_origin = (sx == '0) && (sy == '0);
   assign tick      = (tick_cnt == TW'(TICK_DIV - 1));
   assign state     = st;

   // ---------------------------------------------------------------- scan ----
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sx <= '0;
         sy <= '0;
      end else if (sx == COORD_W'(H_RES - 1)) begin
         sx <= '0;
         sy <= (sy == COORD_W'(V_RES - 1)) ? '0 : sy + 1'b1;
      end else begin
         sx <= sx + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)   tick_cnt <= '0;
      else if (tick) tick_cnt <= '0;
      else           tick_cnt <= tick_cnt + 1'b1;
   end

   // ------------------------------------------------------------- support ----
   // NOTE: every variable written in always_comb gets a default first so no
   // path leaves it unassigned, which would infer a latch.
   always_comb begin
      on_plat = 1'b0;
      for (int i = 0; i < N_PLAT; i++) begin
         if ((ext(char_y) + EW'(12) == ext(plat_y[i*COORD_W +: COORD_W])) &&
             (ext(char_x) + EW'(7)  >= ext(plat_x0[i*COORD_W +: COORD_W])) &&
             (char_x <= plat_x1[i*COORD_W +: COORD_W]))
            on_plat = 1'b1;
      end
   end

   assign supported = (char_y == COORD_W'(GROUND_Y)) || on_plat;

   // ------------------------------------------------------------- physics ----
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         char_x <= '0;
         char_y <= COORD_W'(GROUND_Y);
         st     <= ST_GROUND;
         apex   <= '0;
      end else if (tick) begin
         if (move_right && !move_left) begin
            if (ext(char_x) < EW'(H_RES - 8)) char_x <= char_x + 1'b1;
         end else if (move_left && !move_right) begin
            if (char_x != '0) char_x <= char_x - 1'b1;
         end

         case (st)
            ST_GROUND: begin
               if (!jump_n) begin
                  st   <= ST_RISE;
                  apex <= (ext(char_y) >= EW'(JUMP_H)) ?
                          char_y - COORD_W'(JUMP_H) : '0;
               end else if (!supported) begin
                  st <= ST_FALL;
               end
            end
            ST_RISE: begin
               // Already at the top row: turn around instead of wrapping.
               if (char_y == '0) begin
                  st <= ST_FALL;
               end else begin
                  char_y <= char_y - 1'b1;
                  if (char_y - 1'b1 == apex) st <= ST_FALL;
               end
            end
            ST_FALL: begin
               if (supported) st <= ST_GROUND;
               else           char_y <= char_y + 1'b1;
            end
            default: st <= ST_GROUND;
         endcase
      end
   end

   // -------------------------------------------------- drawn position ----
`ifdef SCENE_RENDERER_FRAME_LATCH_EN
   logic [COORD_W-1:0] snap_x, snap_y;

   // Snapshot registers update on the origin cycle; a coincident tick only
   // changes char_x/char_y at that same edge, so the pre-tick position is kept.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         snap_x <= '0;
         snap_y <= COORD_W'(GROUND_Y);
      end else if (at_origin) begin
         snap_x <= char_x;
         snap_y <= char_y;
      end
   end

   // The origin pixel itself already uses the value being captured.
   assign cx = at_origin ? char_x : snap_x;
   assign cy = at_origin ? char_y : snap_y;
`else
   assign cx = char_x;
   assign cy = char_y;
`endif

   // -------------------------------------------------------------- colour ----
   always_comb begin
      logic [EW-1:0] esx, esy, ecx, ecy;
      esx = ext(sx);
      esy = ext(sy);
      ecx = ext(cx);
      ecy = ext(cy);
      pix = BG_COLOUR;

      for (int i = 0; i < N_PLAT; i++) begin
         if ((sy == plat_y[i*COORD_W +: COORD_W]) &&
             (sx >= plat_x0[i*COORD_W +: COORD_W]) &&
             (sx <= plat_x1[i*COORD_W +: COORD_W]))
            pix = 3'b111;
      end

      if ((esy >= EW'(V_RES - 6)) && !sx[0]) pix = 3'b010;

      // Head: rows cy-5..cy-1, written as additions on the scan side.
      if ((esx >= ecx + EW'(1)) && (esx <= ecx + EW'(6)) &&
          (esy + EW'(5) >= ecy) && (esy + EW'(1) <= ecy))
         pix = 3'b000;

      if ((esx >= ecx) && (esx <= ecx + EW'(7)) &&
          (esy >= ecy) && (esy <= ecy + EW'(7)))
         pix = 3'b101;

      if ((esx >= ecx + EW'(1)) && (esx <= ecx + EW'(6)) &&
          (esy >= ecy + EW'(8)) && (esy <= ecy + EW'(11)))
         pix = 3'b000;

      if (((esx == ecx + EW'(2)) || (esx == ecx + EW'(4))) &&
          (esy + EW'(3) == ecy))
         pix = 3'b100;
   end

   // -------------------------------------------------------- pixel output ----
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         x           <= '0;
         y           <= '0;
         colour      <= BG_COLOUR;
         plot        <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         x           <= sx;
         y           <= sy;
         colour      <= pix;
         plot        <= 1'b1;
         frame_start <= at_origin;
      end
   end

endmodule
